// File: rtl/m_adder_sequencer.sv
// Wide add/subtract sequencer: drives an external 4-bit adder one nibble per clock,
// LSB first, rippling the carry through a register and assembling the W-bit result.
module m_adder_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int SW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry_r;
    logic [SW-1:0]   step_r;
    logic [W-1:0]    sum_r;
    logic            cout_r;
    logic            ovf_r;
    logic            busy_r;
    logic            done_r;
    logic            accept_s;
    logic [SW+1:0]   nib_base_s;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic f_signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
    assign nib_base_s = {step_r, 2'b00};

    // Next-state decode.
    always_comb begin
        state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (step_r == LAST_STEP) state_s = DONE;
                else                     state_s = RUN;
            end
            DONE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Adder operand mux: current nibble of latched operands while running, else zero.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_r == RUN) begin
            add_a   = a_r[nib_base_s +: 4];
            add_b   = b_r[nib_base_s +: 4];
            add_cin = carry_r;
        end else begin
            add_a   = 4'h0;
            add_b   = 4'h0;
            add_cin = 1'b0;
        end
    end

    // State, operand latch, carry ripple and result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            step_r  <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            if (accept_s) begin
                a_r     <= op_a;
                // Subtraction is A + ~B + 1, so invert B once here.
                b_r     <= sub ? ~op_b : op_b;
                carry_r <= sub ? 1'b1 : cin;
                step_r  <= '0;
                sum_r   <= '0;
            end else if (state_r == RUN) begin
                sum_r[nib_base_s +: 4] <= add_s;
                carry_r                <= add_cout;
                if (step_r == LAST_STEP) begin
                    step_r <= '0;
                    cout_r <= add_cout;
                    ovf_r  <= f_signed_ovf(a_r[W-1], b_r[W-1], add_s[3]);
                end else begin
                    step_r <= step_r + SW'(1);
                end
            end else begin
                step_r <= step_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_m_adder_sequencer.sv
// Self-checking bench for m_adder_sequencer: vector table, hand-written corner
// sequences and random operations, with results checked through a scoreboard queue.
module tb_m_adder_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests = 0;
    int fails = 0;
    logic [17:0] sb_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         c;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[9];

    m_adder_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .op_a(op_a), .op_b(op_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Stand-in for the external 4-bit ripple adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                check("result", {46'd0, cout, ovf, sum}, {46'd0, sb_q.pop_front()});
            end
        end
    end

    function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s, input logic c);
        logic [W-1:0] bp;
        logic [W:0]   r;
        bp = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bp} + {16'd0, (s ? 1'b1 : c)};
        return {r[W], (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]), r[W-1:0]};
    endfunction

    // Issue one operation, scramble inputs after acceptance, check latency and busy length.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic c, input logic [17:0] exp);
        int lat;
        int busy_n;
        lat    = 0;
        busy_n = 0;
        @(negedge clk);
        op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
        sb_q.push_back(exp);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; op_a = ~a; op_b = ~b; sub = ~s; cin = ~c;
            end
            if (busy) busy_n++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 5);
        check("busy_cycles", busy_n, 4);
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [3:0] exp_a[4];
        logic [3:0] exp_b[4];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rs;
        logic rc;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 1'b1, 16'hBE02, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {35'd0, busy, done, cout, ovf, sum, add_a, add_b, add_cin}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c,
                   {vecs[i].exp_cout, vecs[i].exp_ovf, vecs[i].exp_sum});

        // Per-cycle adder port values for 0x7FFF + 0x0001.
        exp_a = '{4'hF, 4'hF, 4'hF, 4'h7};
        exp_b = '{4'h1, 4'h0, 4'h0, 4'h0};
        @(negedge clk);
        op_a = 16'h7FFF; op_b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        sb_q.push_back({1'b0, 1'b1, 16'h8000});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("adder_ports_step%0d", k - 1), {55'd0, add_a, add_b, add_cin},
                  {55'd0, exp_a[k-1], exp_b[k-1], (k == 1) ? 1'b0 : 1'b1});
        end
        @(negedge clk);
        check("ports_zero_in_done", {52'd0, done, add_a, add_b, add_cin}, {52'd0, 1'b1, 4'h0, 4'h0, 1'b0});

        // Start during RUN is ignored; start in the done cycle is accepted.
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        sb_q.push_back({1'b0, 1'b0, 16'h3333});
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin op_a = 16'h9999; op_b = 16'h9999; start = 1'b1; end
            if (k == 3) start = 1'b0;
            if (done) begin lat = k; break; end
        end
        check("ignored_start_latency", lat, 5);
        op_a = 16'h0001; op_b = 16'h0001; start = 1'b1;
        sb_q.push_back({1'b0, 1'b0, 16'h0002});
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) begin lat = k; break; end
        end
        check("back_to_back_latency", lat, 5);

        // Reset at RUN step 2 discards the operation.
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_run_reset", {35'd0, busy, done, cout, ovf, sum, add_a, add_b, add_cin}, 64'd0);
        rst = 1'b0;
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("no_done_after_reset", done_seen, 0);
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1010});

        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, rc, model(ra, rb, rs, rc));
        end

        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
